sweep_controller: RTL and testbench

Closed-loop driver for the 32-bit marker rotator: issues single-cycle `left`/`right` step pulses at a programmable rate and watches the rotator's limit sensors. On a limit it dwells, then reverses, so the marker ping-pongs across the ring. It sits between the user enable/start controls and the rotator's `left`/`right`/`sensorA`/`sensorB` pins, and counts completed bounces for display.

---
 rtl/sweep_controller.sv | 165 ++++++++++++++++
 tb/tb_sweep_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_controller.sv
// Step-pulse driver for the marker rotator: ping-pongs between limit sensors
// with a programmable step rate and dwell, and counts completed bounces.
`timescale 1ns/1ps
module sweep_controller #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned DWELL    = 8,
    parameter int unsigned BOUNCE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                start_dir,
    input  logic                sensorA,
    input  logic                sensorB,
    output logic                left,
    output logic                right,
    output logic                moving_left,
    output logic                moving_right,
    output logic                busy,
    output logic [BOUNCE_W-1:0] bounce_count
);

    localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned DW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0] PRE_FIRE = PW'(STEP_DIV - 2);
    localparam logic [DW-1:0] DW_LAST  = DW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN_L,
        S_DWELL_L,
        S_RUN_R,
        S_DWELL_R
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       pre_q, pre_d, pre_nxt;
    logic [DW-1:0]       dw_q, dw_d;
    logic [BOUNCE_W-1:0] cnt_q, cnt_d;
    logic                left_q, left_d;
    logic                right_q, right_d;
    logic                ml_q, ml_d;
    logic                mr_q, mr_d;
    logic                busy_q, busy_d;

    assign pre_nxt = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        dw_d    = dw_q;
        cnt_d   = cnt_q;
        left_d  = 1'b0;
        right_d = 1'b0;
        ml_d    = 1'b0;
        mr_d    = 1'b0;
        busy_d  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                pre_d  = '0;
                dw_d   = '0;
                if (enable) begin
                    state_d = start_dir ? S_RUN_R : S_RUN_L;
                    ml_d    = ~start_dir;
                    mr_d    = start_dir;
                    busy_d  = 1'b1;
                end
            end
            // The pulse fires one count early so it is registered on the wrap.
            S_RUN_L: begin
                if (sensorB) begin
                    state_d = S_DWELL_L;
                    dw_d    = '0;
                    cnt_d   = cnt_q + BOUNCE_W'(1);
                end else begin
                    pre_d  = pre_nxt;
                    left_d = (pre_q == PRE_FIRE);
                    ml_d   = 1'b1;
                end
            end
            S_RUN_R: begin
                if (sensorA) begin
                    state_d = S_DWELL_R;
                    dw_d    = '0;
                    cnt_d   = cnt_q + BOUNCE_W'(1);
                end else begin
                    pre_d   = pre_nxt;
                    right_d = (pre_q == PRE_FIRE);
                    mr_d    = 1'b1;
                end
            end
            S_DWELL_L: begin
                if (dw_q == DW_LAST) begin
                    state_d = S_RUN_R;
                    pre_d   = '0;
                    mr_d    = 1'b1;
                end else begin
                    dw_d = dw_q + DW'(1);
                end
            end
            S_DWELL_R: begin
                if (dw_q == DW_LAST) begin
                    state_d = S_RUN_L;
                    pre_d   = '0;
                    ml_d    = 1'b1;
                end else begin
                    dw_d = dw_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Dropping enable wins over any sensor seen in the same cycle.
        if (!enable && state_q != S_IDLE) begin
            state_d = S_IDLE;
            pre_d   = '0;
            dw_d    = '0;
            cnt_d   = cnt_q;
            left_d  = 1'b0;
            right_d = 1'b0;
            ml_d    = 1'b0;
            mr_d    = 1'b0;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            dw_q    <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            ml_q    <= 1'b0;
            mr_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            dw_q    <= dw_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            right_q <= right_d;
            ml_q    <= ml_d;
            mr_q    <= mr_d;
            busy_q  <= busy_d;
        end
    end

    assign left         = left_q;
    assign right        = right_q;
    assign moving_left  = ml_q;
    assign moving_right = mr_q;
    assign busy         = busy_q;
    assign bounce_count = cnt_q;

endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller: vector table, directed corner sequences,
// random stimulus against an elapsed-time model, and a closed rotator loop.
`timescale 1ns/1ps
module tb_sweep_controller;

    localparam int SD   = 4;
    localparam int DWL  = 8;
    localparam int BW   = 2;
    localparam int LLIM = 4;
    localparam int RLIM = 27;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic sdir = 1'b0;
    logic sA = 1'b0;
    logic sB = 1'b0;
    logic left, right, ml, mr, busy;
    logic [BW-1:0] bc;

    always #5 clk = ~clk;

    sweep_controller #(
        .STEP_DIV(SD),
        .DWELL   (DWL),
        .BOUNCE_W(BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en),
        .start_dir   (sdir),
        .sensorA     (sA),
        .sensorB     (sB),
        .left        (left),
        .right       (right),
        .moving_left (ml),
        .moving_right(mr),
        .busy        (busy),
        .bounce_count(bc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 idle, 1 run, 2 dwell; m_t = cycles elapsed in phase.
    int m_phase = 0;
    bit m_dir = 1'b0;
    int m_t = 0;
    int m_cnt = 0;

    int  pos = 16;
    bit  rot_on = 1'b0;

    task automatic model_edge();
        if (!rst_n) begin
            m_phase = 0;
            m_t     = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            if (en) begin
                m_phase = 1;
                m_dir   = sdir;
                m_t     = 1;
            end
        end else if (!en) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if ((!m_dir && sB) || (m_dir && sA)) begin
                m_phase = 2;
                m_t     = 1;
                m_cnt   = (m_cnt + 1) % (1 << BW);
            end else begin
                m_t++;
            end
        end else begin
            if (m_t == DWL) begin
                m_phase = 1;
                m_dir   = !m_dir;
                m_t     = 1;
            end else begin
                m_t++;
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        logic run, pulse;
        logic [BW-1:0] c;
        run   = (m_phase == 1);
        pulse = run && (m_t % SD == 0);
        c     = BW'(m_cnt);
        return {pulse && !m_dir, pulse && m_dir, run && !m_dir,
                run && m_dir, m_phase != 0, c};
    endfunction

    function automatic logic [6:0] dut_out();
        return {left, right, ml, mr, busy, bc};
    endfunction

    task automatic cmp(input string name, input logic [6:0] got,
                       input logic [6:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        cmp(name, dut_out(), model_out());
        cmp({name, "_mutex"}, {5'b0, left & right, ml & mr}, 7'b0);
    endtask

    // One clock: model and rotator see the values present before the edge.
    task automatic step();
        logic l0, r0;
        l0 = left;
        r0 = right;
        model_edge();
        @(posedge clk);
        #1;
        if (rot_on) begin
            if (l0) pos = (pos + 31) % 32;
            if (r0) pos = (pos + 1) % 32;
            sA = (pos >= RLIM);
            sB = (pos <= LLIM);
        end
    endtask

    typedef struct {
        bit rst_n;
        bit en;
        bit dir;
        bit sa;
        bit sb;
        logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(bit r, bit e, bit d, bit a, bit b,
                                logic [6:0] x);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.dir   = d;
        v.sa    = a;
        v.sb    = b;
        v.exp   = x;
        return v;
    endfunction

    vec_t tbl[24];
    int   seen;
    int   bounces;
    logic [BW-1:0] prev_bc;
    logic [BW-1:0] exp_bc;

    initial begin
        // Expected bits: {left, right, moving_left, moving_right, busy, bc[1:0]}
        for (int i = 0; i < 3; i++) tbl[i] = mk(0, 1, 0, 1, 1, 7'b0000000);
        for (int i = 3; i < 12; i++) tbl[i] = mk(1, 1, 0, 0, 0, 7'b0010100);
        tbl[6]  = mk(1, 1, 0, 0, 0, 7'b1010100);
        tbl[10] = mk(1, 1, 0, 0, 0, 7'b1010100);
        tbl[12] = mk(1, 1, 0, 0, 1, 7'b0000101);
        for (int i = 13; i < 20; i++) tbl[i] = mk(1, 1, 0, 0, 0, 7'b0000101);
        for (int i = 20; i < 23; i++) tbl[i] = mk(1, 1, 0, 0, 0, 7'b0001101);
        tbl[23] = mk(1, 1, 0, 0, 0, 7'b0101101);

        for (int i = 0; i < 24; i++) begin
            rst_n = tbl[i].rst_n;
            en    = tbl[i].en;
            sdir  = tbl[i].dir;
            sA    = tbl[i].sa;
            sB    = tbl[i].sb;
            step();
            cmp($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
        end

        // Wrong-side sensors: sensorB in RUN_R, then limit, then sensorA in RUN_L.
        for (int i = 0; i < 60; i++) begin
            sB = (i < 13) && (i % 3 == 1);
            sA = (i == 13) || (i > 25 && i % 5 == 0);
            step();
            check_model($sformatf("wrong%0d", i));
        end
        sA = 1'b0;
        cmp("wrong_cnt", {5'b0, bc}, 7'd2);
        cmp("wrong_dir", {6'b0, ml}, 7'd1);

        // Abort mid-dwell with a sensor high in the same cycle.
        sB = 1'b1;
        step();
        check_model("abort_lim");
        sB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_model("abort_dwell");
        end
        en = 1'b0;
        sA = 1'b1;
        step();
        cmp("abort_idle", dut_out(), 7'b0000011);
        sA = 1'b0;
        step();
        cmp("abort_hold", dut_out(), 7'b0000011);
        en   = 1'b1;
        sdir = 1'b1;
        step();
        cmp("reenter_r1", dut_out(), 7'b0001111);
        for (int i = 0; i < 3; i++) step();
        cmp("reenter_r4", dut_out(), 7'b0101111);

        // Random stimulus against the model.
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            en    = ($urandom_range(0, 19) != 0);
            sdir  = $urandom_range(0, 1);
            sA    = ($urandom_range(0, 9) == 0);
            sB    = ($urandom_range(0, 9) == 0);
            step();
            check_model("rand");
        end

        // Closed loop with a 32-position rotator model.
        rst_n = 1'b0;
        en    = 1'b0;
        sA    = 1'b0;
        sB    = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        en     = 1'b1;
        sdir   = 1'b0;
        pos    = 16;
        rot_on = 1'b1;
        prev_bc = bc;
        bounces = 0;
        seen    = 0;
        for (int i = 0; i < 3000 && bounces < 4; i++) begin
            step();
            check_model("loop");
            cmp("marker_range", {6'b0, (pos >= LLIM && pos <= RLIM)}, 7'd1);
            if (bc !== prev_bc) begin
                bounces++;
                exp_bc = BW'(bounces % 4);
                cmp($sformatf("loop_bounce%0d", bounces), {5'b0, bc},
                    {5'b0, exp_bc});
                prev_bc = bc;
            end
        end
        if (bounces < 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL loop_timeout: got %0d bounces want 4", bounces);
        end
        rot_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
